alu: RTL and testbench



---
 rtl/alu_if.sv | 24 ++
 rtl/alu.sv | 41 ++++
 tb/tb_alu.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the register file, control decoder and the ALU.
interface alu_if;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [2:0] SELECT;
    logic [7:0] RESULT;
    logic       ZERO;

    modport master (
        output DATA1,
        output DATA2,
        output SELECT,
        input  RESULT,
        input  ZERO
    );

    modport slave (
        input  DATA1,
        input  DATA2,
        input  SELECT,
        output RESULT,
        output ZERO
    );
endinterface

// File: rtl/alu.sv
// 8-bit registered ALU: FORWARD/ADD/AND/OR selected by a 3-bit opcode, one clock of latency.
module alu (
    input  logic   CLK,
    input  logic   RESET,
    alu_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_FWD = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011
    } op_e;

    logic [7:0] result_d;
    logic [7:0] result_q;

    // Reserved opcodes 100..111 fall through to zero.
    always_comb begin
        result_d = '0;
        case (op_e'(bus.SELECT))
            OP_FWD:  result_d = bus.DATA2;
            OP_ADD:  result_d = bus.DATA1 + bus.DATA2;
            OP_AND:  result_d = bus.DATA1 & bus.DATA2;
            OP_OR:   result_d = bus.DATA1 | bus.DATA2;
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign bus.RESULT = result_q;
    assign bus.ZERO   = ~|result_q;

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven checks of the registered ALU plus reset and hold sequences.
module tb_alu;

    logic CLK;
    logic RESET;
    alu_if bus ();

    alu dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
        logic [2:0] sel;
        logic [7:0] exp_res;
        logic       exp_zero;
        string      name;
    } vec_t;

    vec_t vecs [12];
    int   checks;
    int   errors;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] sel);
        bus.DATA1  = d1;
        bus.DATA2  = d2;
        bus.SELECT = sel;
    endtask

    task automatic edge_and_settle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{8'hF0, 8'h0F, 3'b000, 8'h0F, 1'b0, "fwd"};
        vecs[1]  = '{8'hF0, 8'h0F, 3'b001, 8'hFF, 1'b0, "add"};
        vecs[2]  = '{8'hF0, 8'h0F, 3'b010, 8'h00, 1'b1, "and"};
        vecs[3]  = '{8'hF0, 8'h0F, 3'b011, 8'hFF, 1'b0, "or"};
        vecs[4]  = '{8'hFF, 8'h01, 3'b001, 8'h00, 1'b1, "add_wrap"};
        vecs[5]  = '{8'h7F, 8'h01, 3'b001, 8'h80, 1'b0, "add_7f"};
        vecs[6]  = '{8'hAA, 8'h55, 3'b100, 8'h00, 1'b1, "rsv100"};
        vecs[7]  = '{8'hAA, 8'h55, 3'b101, 8'h00, 1'b1, "rsv101"};
        vecs[8]  = '{8'hAA, 8'h55, 3'b110, 8'h00, 1'b1, "rsv110"};
        vecs[9]  = '{8'hAA, 8'h55, 3'b111, 8'h00, 1'b1, "rsv111"};
        vecs[10] = '{8'h3C, 8'h5A, 3'b010, 8'h18, 1'b0, "and_mix"};
        vecs[11] = '{8'h3C, 8'h5A, 3'b011, 8'h7E, 1'b0, "or_mix"};

        // Reset held across clock edges with live operands
        RESET = 1'b1;
        drive(8'hAA, 8'h55, 3'b000);
        #1;
        check8("reset_result", bus.RESULT, 8'h00);
        repeat (3) @(posedge CLK);
        #1;
        check8("reset_hold_result", bus.RESULT, 8'h00);
        check1("reset_hold_zero", bus.ZERO, 1'b1);

        @(negedge CLK);
        RESET = 1'b0;
        edge_and_settle();
        check8("post_reset_result", bus.RESULT, 8'h55);
        check1("post_reset_zero", bus.ZERO, 1'b0);

        // Table vectors, back-to-back one per cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            drive(vecs[i].d1, vecs[i].d2, vecs[i].sel);
            edge_and_settle();
            check8({vecs[i].name, "_result"}, bus.RESULT, vecs[i].exp_res);
            check1({vecs[i].name, "_zero"}, bus.ZERO, vecs[i].exp_zero);
        end

        // Inputs changing between edges must not reach RESULT early
        @(negedge CLK);
        drive(8'hF0, 8'h0F, 3'b011);
        edge_and_settle();
        check8("hold_setup", bus.RESULT, 8'hFF);
        @(negedge CLK);
        drive(8'h00, 8'h11, 3'b000);
        #2;
        check8("hold_between_edges", bus.RESULT, 8'hFF);
        edge_and_settle();
        check8("hold_next_edge", bus.RESULT, 8'h11);

        // Async reset between edges clears immediately
        @(negedge CLK);
        drive(8'hF0, 8'h0F, 3'b001);
        edge_and_settle();
        check8("async_setup", bus.RESULT, 8'hFF);
        #1;
        RESET = 1'b1;
        #1;
        check8("async_result", bus.RESULT, 8'h00);
        check1("async_zero", bus.ZERO, 1'b1);
        edge_and_settle();
        check8("async_no_capture", bus.RESULT, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check8("async_release_wait", bus.RESULT, 8'h00);
        edge_and_settle();
        check8("async_release_capture", bus.RESULT, 8'hFF);
        check1("async_release_zero", bus.ZERO, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
